// File: rtl/fp8_accum_responder_if.sv
// fp8_accum_responder_if
//   Pin-level bundle of the TinyTapeout-style tile that carries the FP8
//   operand protocol between a host and the accumulating responder.
//   Signals:
//     ena      host -> tile  tile enable
//     ui_in    host -> tile  FP8 operand B
//     uio_in   host -> tile  [0] strobe, [1] clear, [7:2] unused
//     uo_out   tile -> host  accumulator A (FP8)
//     uio_out  tile -> host  [7] busy, [6] sticky overflow, [5:0] zero
//     uio_oe   tile -> host  bidirectional pin output enables
//   Modports: master = host side, slave = tile side.
interface fp8_accum_responder_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ena, ui_in, uio_in,
    input  uo_out, uio_out, uio_oe
  );

  modport slave (
    input  ena, ui_in, uio_in,
    output uo_out, uio_out, uio_oe
  );
endinterface

// File: rtl/fp8_accum_responder.sv
// fp8_accum_responder
//   Accumulates a stream of FP8 operands into a running FP8 sum.
//   Each rising edge of the strobe (while idle) captures one operand and
//   runs a four-cycle ALIGN -> ADD -> NORM -> WRITE sequence that adds it to
//   the accumulator, truncating the exact sum toward zero.
//   FP8: [7] sign, [6:3] exponent (bias 7), [2:0] fraction; exponent 0 is
//   subnormal, no inf/NaN. Magnitudes above 480 saturate and set a sticky
//   overflow flag.
//   Ports:
//     clk    clock
//     rst_n  asynchronous active-low reset
//     bus    slave side of fp8_accum_responder_if (ena, ui_in, uio_in,
//            uo_out, uio_out, uio_oe)
module fp8_accum_responder #(
  parameter logic [7:0] ACC_RESET = 8'h00,
  parameter int         GRS_BITS  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fp8_accum_responder_if.slave  bus
);

  // Working mantissa: hidden bit + 3 fraction bits + guard/round/sticky.
  localparam int MW = 4 + GRS_BITS;
  localparam int SW = MW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIGN,
    S_ADD,
    S_NORM,
    S_WRITE
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic          w_busy;
  logic          w_clear;
  logic          w_accept;

  logic          r_strb_q;
  logic [7:0]    r_acc;
  logic [7:0]    r_b;
  logic          r_ovf;

  logic [MW-1:0] r_big_al;
  logic [MW-1:0] r_small_al;
  logic          r_big_s;
  logic          r_small_s;
  logic [3:0]    r_exp;

  logic [SW-1:0] r_sum;
  logic          r_sum_s;

  logic [7:0]    r_res;
  logic          r_res_ovf;

  logic          w_unused;
  assign w_unused = &{1'b0, bus.uio_in[7:2]};

  // ---------------------------------------------------------------- FSM
  assign w_clear = bus.ena & bus.uio_in[1];

  always_comb begin
    w_state_next = r_state;
    w_busy       = (r_state != S_IDLE);
    // Clear wins over a same-cycle strobe edge.
    w_accept     = bus.ena & bus.uio_in[0] & ~r_strb_q &
                   (r_state == S_IDLE) & ~w_clear;
    if (bus.ena) begin
      if (w_clear) begin
        w_state_next = S_IDLE;
      end else begin
        case (r_state)
          S_IDLE:  if (w_accept) w_state_next = S_ALIGN;
          S_ALIGN: w_state_next = S_ADD;
          S_ADD:   w_state_next = S_NORM;
          S_NORM:  w_state_next = S_WRITE;
          S_WRITE: w_state_next = S_IDLE;
          default: w_state_next = S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // -------------------------------------------------------------- ALIGN
  logic [3:0]      w_ea, w_eb, w_big_e, w_small_e, w_diff;
  logic [3:0]      w_ma, w_mb, w_big_m, w_small_m;
  logic            w_a_big;
  logic [2*MW-1:0] w_shift_full;
  logic [MW-1:0]   w_small_al;

  // Subnormals use effective exponent 1 with a clear hidden bit.
  assign w_ea = (r_acc[6:3] == 4'd0) ? 4'd1 : r_acc[6:3];
  assign w_eb = (r_b[6:3] == 4'd0)   ? 4'd1 : r_b[6:3];
  assign w_ma = {(r_acc[6:3] != 4'd0), r_acc[2:0]};
  assign w_mb = {(r_b[6:3] != 4'd0), r_b[2:0]};

  assign w_a_big   = (w_ea >= w_eb);
  assign w_big_e   = w_a_big ? w_ea : w_eb;
  assign w_small_e = w_a_big ? w_eb : w_ea;
  assign w_big_m   = w_a_big ? w_ma : w_mb;
  assign w_small_m = w_a_big ? w_mb : w_ma;
  assign w_diff    = w_big_e - w_small_e;

  // The lower half of the double-width shift collects the bits that fall
  // off; their OR becomes the sticky bit in the LSB.
  assign w_shift_full = {w_small_m, {(GRS_BITS + MW){1'b0}}} >> w_diff;
  assign w_small_al   = (w_diff >= 4'(MW - 1))
                      ? {{(MW-1){1'b0}}, |w_small_m}
                      : (w_shift_full[2*MW-1:MW] |
                         {{(MW-1){1'b0}}, |w_shift_full[MW-1:0]});

  // ---------------------------------------------------------------- ADD
  logic          w_sub;
  logic [SW-1:0] w_sum;
  logic          w_sum_s;

  always_comb begin
    w_sub   = r_big_s ^ r_small_s;
    w_sum   = {1'b0, r_big_al} + {1'b0, r_small_al};
    w_sum_s = r_big_s;
    if (w_sub) begin
      if (r_big_al >= r_small_al) begin
        w_sum   = {1'b0, r_big_al} - {1'b0, r_small_al};
        w_sum_s = r_big_s;
      end else begin
        w_sum   = {1'b0, r_small_al} - {1'b0, r_big_al};
        w_sum_s = r_small_s;
      end
    end
    if (w_sum == '0) begin
      w_sum_s = 1'b0;
    end
  end

  // --------------------------------------------------------------- NORM
  logic [3:0]    w_lz;
  logic [3:0]    w_sh;
  logic [MW-1:0] w_norm;
  logic [4:0]    w_exp_n;
  logic [3:0]    w_field;
  logic          w_ovf_n;
  logic [7:0]    w_res;

  always_comb begin
    w_lz = 4'(MW);
    for (int i = 0; i < MW; i++) begin
      if (r_sum[i]) w_lz = 4'(MW - 1 - i);
    end
    // Never shift the exponent below 1: what remains is a subnormal.
    w_sh = (w_lz < (r_exp - 4'd1)) ? w_lz : (r_exp - 4'd1);
    if (r_sum[SW-1]) begin
      w_norm  = r_sum[SW-1:1] | {{(MW-1){1'b0}}, r_sum[0]};
      w_exp_n = {1'b0, r_exp} + 5'd1;
    end else begin
      w_norm  = r_sum[MW-1:0] << w_sh;
      w_exp_n = {1'b0, r_exp} - {1'b0, w_sh};
    end
    w_field = w_norm[MW-1] ? w_exp_n[3:0] : 4'd0;
    // Overflow is any exact magnitude above 480: either the exponent left
    // the 4-bit range, or the value is 1.111 x 2^8 with nonzero residue.
    w_ovf_n = w_exp_n[4] ||
              ((w_exp_n == 5'd15) && (w_norm[MW-1 -: 4] == 4'hF) &&
               (|w_norm[GRS_BITS-1:0]));
    w_res   = w_ovf_n ? {r_sum_s, 7'h7F}
                      : {r_sum_s, w_field, w_norm[MW-2 -: 3]};
  end

  // ----------------------------------------------------------- Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_strb_q   <= 1'b0;
      r_acc      <= ACC_RESET;
      r_b        <= 8'h00;
      r_ovf      <= 1'b0;
      r_big_al   <= '0;
      r_small_al <= '0;
      r_big_s    <= 1'b0;
      r_small_s  <= 1'b0;
      r_exp      <= 4'd1;
      r_sum      <= '0;
      r_sum_s    <= 1'b0;
      r_res      <= 8'h00;
      r_res_ovf  <= 1'b0;
    end else if (bus.ena) begin
      r_strb_q <= bus.uio_in[0];
      if (w_clear) begin
        r_acc <= ACC_RESET;
        r_ovf <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_accept) r_b <= bus.ui_in;
          end
          S_ALIGN: begin
            r_big_al   <= {w_big_m, {GRS_BITS{1'b0}}};
            r_small_al <= w_small_al;
            r_big_s    <= w_a_big ? r_acc[7] : r_b[7];
            r_small_s  <= w_a_big ? r_b[7] : r_acc[7];
            r_exp      <= w_big_e;
          end
          S_ADD: begin
            r_sum   <= w_sum;
            r_sum_s <= w_sum_s;
          end
          S_NORM: begin
            r_res     <= w_res;
            r_res_ovf <= w_ovf_n;
          end
          S_WRITE: begin
            r_acc <= r_res;
            r_ovf <= r_ovf | r_res_ovf;
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign bus.uo_out  = r_acc;
  assign bus.uio_out = {w_busy, r_ovf, 6'b000000};
  assign bus.uio_oe  = 8'hC0;

endmodule

// File: tb/tb_fp8_accum_responder.sv
// tb_fp8_accum_responder
//   Directed and random stimulus for fp8_accum_responder. The reference
//   model works on exact integer values in units of 2^-9 (the smallest
//   subnormal), so every sum is exact and the expected FP8 code is the
//   truncated re-encoding of that integer.
module tb_fp8_accum_responder;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  logic [7:0] acc_m;
  bit         ovf_m;

  fp8_accum_responder_if bus ();

  fp8_accum_responder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ------------------------------------------------------------ model
  function automatic int fp8_val(input logic [7:0] v);
    int mag;
    if (v[6:3] == 4'd0) mag = int'(v[2:0]);
    else                mag = (8 + int'(v[2:0])) << (int'(v[6:3]) - 1);
    return v[7] ? -mag : mag;
  endfunction

  function automatic void fp8_encode(input int x, output logic [7:0] code,
                                     output bit ov);
    int   m;
    int   e;
    int   q;
    logic s;
    s  = (x < 0);
    m  = s ? -x : x;
    ov = 1'b0;
    if (m > 480 * 512) begin
      code = {s, 7'h7F};
      ov   = 1'b1;
    end else if (m == 0) begin
      code = 8'h00;
    end else if (m < 8) begin
      code = {s, 4'd0, 3'(m)};
    end else begin
      e = 1;
      while ((m >> (e - 1)) >= 16) e++;
      q    = (m >> (e - 1)) - 8;
      code = {s, 4'(e), 3'(q)};
    end
  endfunction

  task automatic model_add(input logic [7:0] b);
    logic [7:0] code;
    bit         ov;
    fp8_encode(fp8_val(acc_m) + fp8_val(b), code, ov);
    acc_m = code;
    ovf_m = ovf_m | ov;
  endtask

  // ------------------------------------------------------------ helpers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check8(input string tag, input logic [7:0] obs,
                        input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic do_add(input string tag, input logic [7:0] b);
    logic [7:0] old_acc;
    old_acc       = acc_m;
    bus.ui_in     = b;
    bus.uio_in[0] = 1'b1;
    tick();
    bus.uio_in[0] = 1'b0;
    bus.ui_in     = 8'($urandom);
    repeat (4) begin
      check8({tag, "_busy"}, bus.uio_out, {1'b1, ovf_m, 6'b0});
      check8({tag, "_hold"}, bus.uo_out, old_acc);
      tick();
    end
    model_add(b);
    check8({tag, "_acc"}, bus.uo_out, acc_m);
    check8({tag, "_stat"}, bus.uio_out, {1'b0, ovf_m, 6'b0});
    $display("add %s: b=%02h acc=%02h uio_out=%02h", tag, b, bus.uo_out,
             bus.uio_out);
  endtask

  task automatic do_clear();
    bus.uio_in[1] = 1'b1;
    tick();
    bus.uio_in[1] = 1'b0;
    acc_m = 8'h00;
    ovf_m = 1'b0;
    check8("clear_acc", bus.uo_out, 8'h00);
    check8("clear_stat", bus.uio_out, 8'h00);
    $display("clear: acc=%02h uio_out=%02h", bus.uo_out, bus.uio_out);
  endtask

  // ------------------------------------------------------------ stimulus
  initial begin
    logic [7:0] rb;
    n_vec      = 0;
    n_err      = 0;
    acc_m      = 8'h00;
    ovf_m      = 1'b0;
    rst_n      = 1'b0;
    bus.ena    = 1'b1;
    bus.ui_in  = 8'h00;
    bus.uio_in = 8'h00;

    repeat (2) @(posedge clk);
    #1;
    check8("rst_acc", bus.uo_out, 8'h00);
    check8("rst_stat", bus.uio_out, 8'h00);
    check8("rst_oe", bus.uio_oe, 8'hC0);
    rst_n = 1'b1;
    tick();

    // Basic accumulation
    do_add("p1_0", 8'h38);
    check8("tp_1p0", bus.uo_out, 8'h38);
    do_add("p2_0", 8'h38);
    check8("tp_2p0", bus.uo_out, 8'h40);
    check8("tp_2p0_ovf", {7'b0, bus.uio_out[6]}, 8'h00);

    do_clear();
    do_add("s1_0", 8'h38);
    do_add("s1_5", 8'h30);
    check8("tp_1p5", bus.uo_out, 8'h3C);
    do_add("s0_5", 8'hB8);
    check8("tp_0p5", bus.uo_out, 8'h30);
    do_add("szero", 8'hB0);
    check8("tp_zero", bus.uo_out, 8'h00);

    // Subnormal and hidden-bit transition
    do_clear();
    do_add("sub1", 8'h01);
    do_add("sub2", 8'h01);
    check8("tp_sub2", bus.uo_out, 8'h02);
    do_add("sub9", 8'h07);
    check8("tp_sub9", bus.uo_out, 8'h09);

    // Overflow saturation and sticky flag
    do_clear();
    do_add("ov1", 8'h7F);
    do_add("ov2", 8'h7F);
    check8("tp_ov_acc", bus.uo_out, 8'h7F);
    check8("tp_ov_flag", {7'b0, bus.uio_out[6]}, 8'h01);
    do_add("ov3", 8'hB8);
    check8("tp_ov_479", bus.uo_out, 8'h7E);
    check8("tp_ov_sticky", {7'b0, bus.uio_out[6]}, 8'h01);
    do_clear();

    // Strobe held high for 10 cycles: exactly one add
    do_add("hold_pre", 8'h38);
    bus.ui_in     = 8'h38;
    bus.uio_in[0] = 1'b1;
    repeat (10) tick();
    bus.uio_in[0] = 1'b0;
    repeat (2) tick();
    model_add(8'h38);
    check8("held_acc", bus.uo_out, acc_m);
    check8("held_stat", bus.uio_out, 8'h00);
    $display("held strobe: acc=%02h", bus.uo_out);

    // Second edge while busy is dropped, not queued
    bus.ui_in     = 8'h30;
    bus.uio_in[0] = 1'b1;
    tick();
    bus.uio_in[0] = 1'b0;
    tick();
    bus.ui_in     = 8'h38;
    bus.uio_in[0] = 1'b1;
    tick();
    bus.uio_in[0] = 1'b0;
    repeat (2) tick();
    model_add(8'h30);
    check8("busy_edge_acc", bus.uo_out, acc_m);
    repeat (6) tick();
    check8("busy_edge_noq", bus.uo_out, acc_m);
    check8("busy_edge_idle", bus.uio_out, 8'h00);
    $display("edge while busy: acc=%02h", bus.uo_out);

    // Clear during ADD aborts the operation
    bus.ui_in     = 8'h38;
    bus.uio_in[0] = 1'b1;
    tick();
    bus.uio_in[0] = 1'b0;
    tick();
    bus.uio_in[1] = 1'b1;
    tick();
    bus.uio_in[1] = 1'b0;
    acc_m = 8'h00;
    ovf_m = 1'b0;
    check8("abort_acc", bus.uo_out, 8'h00);
    check8("abort_stat", bus.uio_out, 8'h00);
    repeat (4) tick();
    check8("abort_late", bus.uo_out, 8'h00);
    $display("clear in ADD: acc=%02h uio_out=%02h", bus.uo_out, bus.uio_out);

    // Clear and strobe edge in the same cycle: clear wins
    do_add("pri_pre", 8'h38);
    bus.ui_in  = 8'h38;
    bus.uio_in = 8'h03;
    tick();
    bus.uio_in = 8'h00;
    acc_m = 8'h00;
    repeat (5) tick();
    check8("prio_acc", bus.uo_out, 8'h00);
    check8("prio_stat", bus.uio_out, 8'h00);
    $display("clear+strobe: acc=%02h", bus.uo_out);

    // ena low: strobe and clear ignored, edge not seen afterwards
    do_add("ena_pre", 8'h38);
    bus.ena       = 1'b0;
    bus.ui_in     = 8'h38;
    bus.uio_in[0] = 1'b1;
    repeat (2) tick();
    bus.uio_in[0] = 1'b0;
    bus.uio_in[1] = 1'b1;
    tick();
    bus.uio_in[1] = 1'b0;
    bus.ena       = 1'b1;
    repeat (6) tick();
    check8("ena_acc", bus.uo_out, acc_m);
    check8("ena_stat", bus.uio_out, 8'h00);
    $display("ena low: acc=%02h", bus.uo_out);

    // Asynchronous reset during NORM, no clock edge
    bus.ui_in     = 8'h38;
    bus.uio_in[0] = 1'b1;
    tick();
    bus.uio_in[0] = 1'b0;
    repeat (2) tick();
    check8("nrm_busy", bus.uio_out, 8'h80);
    #2 rst_n = 1'b0;
    #1;
    check8("arst_acc", bus.uo_out, 8'h00);
    check8("arst_stat", bus.uio_out, 8'h00);
    check8("arst_oe", bus.uio_oe, 8'hC0);
    $display("async reset in NORM: acc=%02h uio_out=%02h", bus.uo_out,
             bus.uio_out);
    #2 rst_n = 1'b1;
    acc_m = 8'h00;
    ovf_m = 1'b0;
    repeat (6) tick();
    check8("arst_discard", bus.uo_out, 8'h00);

    // Random operands against the exact-value model
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) == 0) do_clear();
      rb = 8'($urandom_range(0, 255));
      do_add("rnd", rb);
    end
    check8("end_oe", bus.uio_oe, 8'hC0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
